// File: rtl/ppc_types.sv
// Shared types for the memory-port path: requester IDs and the request payload bundle.
package ppc_types;

  localparam int MEM_RS_ID_WIDTH = 5;

  typedef logic mem_port_id_t;

  typedef struct packed {
    logic [MEM_RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]                 reg_addr;
    logic [31:0]                address;
    logic [3:0]                 write_en;
    logic [3:0]                 read_en;
    logic [31:0]                write_data;
  } mem_req_t;

endpackage

// File: rtl/id_fifo.sv
// Small in-order FIFO with wrap-bit pointers; a push into a full FIFO is taken only
// when a pop frees the head slot in the same cycle.
module id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] slots [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = slots[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr[AW-1:0]] <= din;
        wr_ptr                <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (0) and load/store (1);
// an ID FIFO steers in-order responses back to the requester that issued them.
module mem_port_arbiter
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   req_valid_0,
  output logic                   req_ready_0,
  input  logic [RS_ID_WIDTH-1:0] req_rs_id_0,
  input  logic [4:0]             req_reg_addr_0,
  input  logic [31:0]            req_address_0,
  input  logic [3:0]             req_write_en_0,
  input  logic [3:0]             req_read_en_0,
  input  logic [31:0]            req_write_data_0,
  output logic                   resp_valid_0,
  input  logic                   resp_ready_0,
  output logic [RS_ID_WIDTH-1:0] resp_rs_id_0,
  output logic [4:0]             resp_reg_addr_0,
  output logic [31:0]            resp_data_0,

  input  logic                   req_valid_1,
  output logic                   req_ready_1,
  input  logic [RS_ID_WIDTH-1:0] req_rs_id_1,
  input  logic [4:0]             req_reg_addr_1,
  input  logic [31:0]            req_address_1,
  input  logic [3:0]             req_write_en_1,
  input  logic [3:0]             req_read_en_1,
  input  logic [31:0]            req_write_data_1,
  output logic                   resp_valid_1,
  input  logic                   resp_ready_1,
  output logic [RS_ID_WIDTH-1:0] resp_rs_id_1,
  output logic [4:0]             resp_reg_addr_1,
  output logic [31:0]            resp_data_1,

  output logic                   to_mem_valid,
  input  logic                   to_mem_ready,
  output logic [RS_ID_WIDTH-1:0] to_mem_rs_id,
  output logic [4:0]             to_mem_reg_addr,
  output logic [31:0]            mem_address,
  output logic [3:0]             mem_write_en,
  output logic [3:0]             mem_read_en,
  output logic [31:0]            mem_write_data,

  input  logic                   from_mem_valid,
  output logic                   from_mem_ready,
  input  logic [RS_ID_WIDTH-1:0] from_mem_rs_id,
  input  logic [4:0]             from_mem_reg_addr,
  input  logic [31:0]            mem_read_data,

  output logic                   resp_error
);

  mem_req_t     req_in [2];
  mem_req_t     stage;
  mem_port_id_t prio;
  mem_port_id_t grant;
  mem_port_id_t head;
  logic         any_grant;
  logic         out_load;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pop;
  logic         accept;
  logic [1:0]   valid_vec;
  logic [1:0]   resp_ready_vec;

  assign req_in[0] = '{rs_id: MEM_RS_ID_WIDTH'(req_rs_id_0), reg_addr: req_reg_addr_0,
                       address: req_address_0, write_en: req_write_en_0,
                       read_en: req_read_en_0, write_data: req_write_data_0};
  assign req_in[1] = '{rs_id: MEM_RS_ID_WIDTH'(req_rs_id_1), reg_addr: req_reg_addr_1,
                       address: req_address_1, write_en: req_write_en_1,
                       read_en: req_read_en_1, write_data: req_write_data_1};

  assign valid_vec      = {req_valid_1, req_valid_0};
  assign resp_ready_vec = {resp_ready_1, resp_ready_0};

  always_comb begin
    any_grant = 1'b1;
    grant     = prio;
    if (valid_vec[prio])       grant = prio;
    else if (valid_vec[~prio]) grant = ~prio;
    else                       any_grant = 1'b0;
  end

  assign out_load = ~to_mem_valid | to_mem_ready;
  assign pop      = from_mem_valid & ~fifo_empty & resp_ready_vec[head];
  // A full FIFO still takes a request when the head response leaves this cycle.
  assign accept   = any_grant & out_load & (~fifo_full | pop);

  assign req_ready_0 = rst_n & accept & (grant == 1'b0);
  assign req_ready_1 = rst_n & accept & (grant == 1'b1);

  id_fifo #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .din   (grant),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_mem_valid <= 1'b0;
      stage        <= '0;
      prio         <= 1'b0;
    end else if (accept) begin
      to_mem_valid <= 1'b1;
      stage        <= req_in[grant];
      prio         <= ~grant;
    end else if (to_mem_ready) begin
      to_mem_valid <= 1'b0;
    end
  end

  // Responses with nothing outstanding are drained and flagged, never delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           resp_error <= 1'b0;
    else if (from_mem_valid & fifo_empty) resp_error <= 1'b1;
  end

  assign to_mem_rs_id    = RS_ID_WIDTH'(stage.rs_id);
  assign to_mem_reg_addr = stage.reg_addr;
  assign mem_address     = stage.address;
  assign mem_write_en    = stage.write_en;
  assign mem_read_en     = stage.read_en;
  assign mem_write_data  = stage.write_data;

  assign from_mem_ready = rst_n & (fifo_empty ? from_mem_valid : resp_ready_vec[head]);
  assign resp_valid_0   = from_mem_valid & ~fifo_empty & (head == 1'b0);
  assign resp_valid_1   = from_mem_valid & ~fifo_empty & (head == 1'b1);

  assign resp_rs_id_0    = from_mem_rs_id;
  assign resp_reg_addr_0 = from_mem_reg_addr;
  assign resp_data_0     = mem_read_data;
  assign resp_rs_id_1    = from_mem_rs_id;
  assign resp_reg_addr_1 = from_mem_reg_addr;
  assign resp_data_1     = mem_read_data;

endmodule
